synthesizer: RTL and testbench
==============================

SYNTHESIZER -- requirements
Module: synthesizer

Interface
REQ-001 The clock SHALL be `clk`, input, 1 bit; one rising edge equals one audio sample.
REQ-002 The reset SHALL be `reset`, input, 1 bit, asynchronous and active-high; this is already decided.
REQ-003 `clock_speed` SHALL be an input, 32-bit unsigned integer giving the sample rate in Hz (nominal 48000).
REQ-004 `cutoff` SHALL be an input, 3 bits, selecting the low-pass filter shift; 0 means bypass.
REQ-005 `square_volume` SHALL be an input, 32-bit signed Q12.20 gain for the square waveform (1<<20 = 1.0).
REQ-006 `saw_volume` SHALL be an input, 32-bit signed Q12.20 gain for the saw waveform.
REQ-007 `frequency[15:0]` SHALL be an input array of 16 signed 32-bit Q12.20 voice frequencies in Hz.
REQ-008 `synth_out` SHALL be an output, 16-bit signed audio sample, registered.

Function
REQ-009 Each voice SHALL hold a 32-bit unsigned phase accumulator.
REQ-010 Each voice's phase increment SHALL be inc = (frequency << 12) / clock_speed, using 64-bit intermediates and truncation.
REQ-011 inc SHALL be 0 when clock_speed is 0 or frequency is <= 0.
REQ-012 Phase SHALL advance by inc on every clock edge and wrap modulo 2^32.
REQ-013 saw SHALL be the signed interpretation of phase[31:16], spanning -32768..32767.
REQ-014 square SHALL be +32767 when phase[31] is 0 and -32768 otherwise.
REQ-015 voice = ((square*square_volume) >>> 20) + ((saw*saw_volume) >>> 20), computed signed at 64 bits.
REQ-016 mix SHALL be the sum of the 16 voice values arithmetically shifted right by 4 (mean), carried at 64 bits.
REQ-017 The filter SHALL be y_next = y + ((mix - y) >>> cutoff), with y a 32-bit signed state.
REQ-018 With cutoff = 0, y_next SHALL equal mix.
REQ-019 synth_out SHALL be y_next saturated to the range -32768..32767.
REQ-020 On each edge, synth_out and y SHALL update from the current phases, and the phases SHALL then advance; output latency is 1 cycle from phase.
REQ-021 Input changes SHALL take effect on the next edge; no handshake exists.
REQ-022 A mid-note change of frequency or cutoff SHALL NOT reset the phase or the filter state.

Reset
REQ-023 While reset is high, all phases, the filter state y and synth_out SHALL be 0.
REQ-024 Reset assertion SHALL act immediately, regardless of clk.
REQ-025 On the first edge after reset deasserts, the output SHALL be computed from phase 0.

Structure
REQ-026 Package `fixed_point_math` SHALL hold the Q12.20 constants (FRAC_BITS=20, ONE=1<<20), NUM_VOICES=16 and the sample width types.
REQ-027 The Q12.20 arithmetic SHALL reuse the existing `Divider` ((a<<20)/b) and `Multiplier` ((a*b)>>20) modules.
REQ-028 The existing `Divider` and `Multiplier` are combinational and are not redefined here.
REQ-029 One per-voice sub-module `synth_oscillator` SHALL hold the phase, the increment and the waveforms, instantiated 16 times.

Verification
REQ-030 Reset test: assert reset with any inputs -> synth_out = 0 immediately and held; first edge after release with all frequencies = 0, volumes 1<<19, cutoff 0 -> synth_out = 16383 constant.
REQ-031 Waveform test: clock_speed = 48000, all frequencies = 12000<<20, volumes 1<<19, cutoff 0 -> repeating sequence 16383, 24575, -32768, -24576.
REQ-032 Filter test: cutoff = 1, all frequencies = 0, volumes 1<<19 -> synth_out 8191, 12287, 14335, ... converging to 16383.
REQ-033 Saturation test: square_volume = 1<<21, saw_volume = 0, frequencies = 0 -> synth_out = 32767.
REQ-034 Guard test: clock_speed = 0, any frequency -> phases frozen and synth_out constant at 16383 (volumes 1<<19).
REQ-035 Mid-run reset test: assert reset during the REQ-031 sequence -> output 0 at once, and the sequence restarts at 16383 after release.

Source files
------------

// File: rtl/fixed_point_math.sv
// Q12.20 fixed-point constants, sample types and shared arithmetic helpers
// for the polyphonic synthesizer.
package fixed_point_math;

  localparam int unsigned FRAC_BITS  = 20;
  localparam int unsigned NUM_VOICES = 16;
  localparam int unsigned MIX_SHIFT  = $clog2(NUM_VOICES);
  // A Q12.20 frequency shifted by this lands at 32 fractional bits: cycles per sample.
  localparam int unsigned INC_SHIFT  = 32 - FRAC_BITS;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [31:0] q12_20_t;
  typedef logic signed [63:0] wide_t;

  localparam q12_20_t ONE        = 32'sh0010_0000;
  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  // Phase increment: (freq << 12) / rate, truncated. Non-positive freq or a
  // zero rate freezes the oscillator.
  function automatic logic [31:0] phase_inc(input q12_20_t freq, input logic [31:0] rate);
    logic [63:0] num;
    logic [31:0] r;
    r = '0;
    if (rate != '0 && freq > 0) begin
      num = {32'd0, freq} << INC_SHIFT;
      r   = 32'(num / {32'd0, rate});
    end
    return r;
  endfunction

  // Q12.20 gain applied to a raw sample: (s * gain) >>> 20 at 64 bits.
  function automatic wide_t q_scale(input sample_t s, input q12_20_t gain);
    wide_t p;
    p = wide_t'(s) * wide_t'(gain);
    return p >>> FRAC_BITS;
  endfunction

  function automatic sample_t saturate(input wide_t v);
    sample_t r;
    if (v > wide_t'(SAMPLE_MAX))
      r = SAMPLE_MAX;
    else if (v < wide_t'(SAMPLE_MIN))
      r = SAMPLE_MIN;
    else
      r = sample_t'(v[15:0]);
    return r;
  endfunction

endpackage

// File: rtl/synth_oscillator.sv
// One synthesizer voice: phase accumulator, square/saw waveforms and the
// volume-weighted voice value derived from the current phase.
module synth_oscillator
  import fixed_point_math::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         clock_speed,
  input  logic signed [31:0]  frequency,
  input  logic signed [31:0]  square_volume,
  input  logic signed [31:0]  saw_volume,
  output logic signed [63:0]  voice
);

  logic [31:0] phase;
  logic [31:0] inc;
  sample_t     saw;
  sample_t     square;

  always_comb begin
    inc = phase_inc(frequency, clock_speed);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      phase <= '0;
    else
      phase <= phase + inc;
  end

  always_comb begin
    saw    = sample_t'(phase[31:16]);
    square = phase[31] ? SAMPLE_MIN : SAMPLE_MAX;
    voice  = q_scale(square, square_volume) + q_scale(saw, saw_volume);
  end

endmodule

// File: rtl/synthesizer.sv
// Sixteen-voice square/saw synthesizer: mean mix of all voices through a
// one-pole shift low-pass filter, saturated to a registered 16-bit sample.
module synthesizer
  import fixed_point_math::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         clock_speed,
  input  logic [2:0]          cutoff,
  input  logic signed [31:0]  square_volume,
  input  logic signed [31:0]  saw_volume,
  input  logic signed [31:0]  frequency [15:0],
  output logic signed [15:0]  synth_out
);

  wide_t   voice [NUM_VOICES];
  wide_t   sum;
  wide_t   mix;
  wide_t   y_next;
  q12_20_t y;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    synth_oscillator u_osc (
      .clk           (clk),
      .reset         (reset),
      .clock_speed   (clock_speed),
      .frequency     (frequency[v]),
      .square_volume (square_volume),
      .saw_volume    (saw_volume),
      .voice         (voice[v])
    );
  end

  // Output and filter state use the pre-advance phases; the oscillators
  // advance on the same edge, giving one cycle of latency from phase.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++)
      sum = sum + voice[i];
    mix    = sum >>> MIX_SHIFT;
    y_next = wide_t'(y) + ((mix - wide_t'(y)) >>> cutoff);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y         <= '0;
      synth_out <= '0;
    end else begin
      y         <= y_next[31:0];
      synth_out <= saturate(y_next);
    end
  end

endmodule

// File: tb/tb_synthesizer.sv
// Scoreboard bench for the synthesizer: directed spec sequences plus
// randomized segments against a behavioural model of voices, mix and filter.
module tb_synthesizer;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [31:0]        clock_speed;
  logic [2:0]         cutoff;
  logic signed [31:0] square_volume;
  logic signed [31:0] saw_volume;
  logic signed [31:0] frequency [15:0];
  logic signed [15:0] synth_out;

  int    checks = 0;
  int    errors = 0;
  int    exp_q[$];
  string name_q[$];
  bit    stim_done = 1'b0;

  longint m_phase [16];
  longint m_y;

  int wave [4] = '{16383, 24575, -32768, -24576};

  synthesizer dut (
    .clk           (clk),
    .reset         (reset),
    .clock_speed   (clock_speed),
    .cutoff        (cutoff),
    .square_volume (square_volume),
    .saw_volume    (saw_volume),
    .frequency     (frequency),
    .synth_out     (synth_out)
  );

  always #5 clk = ~clk;

  function automatic longint model_inc(input longint f, input longint cs);
    if (cs == 0 || f <= 0) return 0;
    return ((f * 4096) / cs) & 64'hFFFF_FFFF;
  endfunction

  // Output of the coming edge from the current phases, then advance phases.
  task automatic model_step(output int result);
    longint total, mix, yn, saw, sq, cs;
    if (reset) begin
      for (int i = 0; i < 16; i++) m_phase[i] = 0;
      m_y = 0;
      result = 0;
      return;
    end
    cs = longint'({32'd0, clock_speed});
    total = 0;
    for (int i = 0; i < 16; i++) begin
      saw = m_phase[i] / 65536;
      if (saw >= 32768) saw = saw - 65536;
      sq = (m_phase[i] < 64'h8000_0000) ? 32767 : -32768;
      total += (sq * longint'(square_volume)) >>> 20;
      total += (saw * longint'(saw_volume)) >>> 20;
    end
    mix = total >>> 4;
    yn  = m_y + ((mix - m_y) >>> cutoff);
    m_y = longint'(int'(yn));
    if (yn > 32767) result = 32767;
    else if (yn < -32768) result = -32768;
    else result = int'(yn);
    for (int i = 0; i < 16; i++)
      m_phase[i] = (m_phase[i] + model_inc(longint'(frequency[i]), cs)) & 64'hFFFF_FFFF;
  endtask

  // Called at a falling edge with inputs already set for the next rising edge.
  task automatic cycle(input string name, input bit has_lit = 1'b0, input int lit = 0);
    int m;
    model_step(m);
    exp_q.push_back(has_lit ? lit : m);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  task automatic check_now(input string name, input int expv);
    checks++;
    if (synth_out !== 16'(expv)) begin
      errors++;
      $display("FAIL %s: synth_out=%0d expected %0d", name, synth_out, expv);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cycle("reset_hold", 1'b1, 0);
    reset = 1'b0;
  endtask

  task automatic set_all_freq(input logic signed [31:0] f);
    for (int i = 0; i < 16; i++) frequency[i] = f;
  endtask

  task automatic randomize_inputs();
    int sel;
    sel = int'($urandom_range(0, 3));
    case (sel)
      0:       clock_speed = 32'd48000;
      1:       clock_speed = 32'd44100;
      2:       clock_speed = $urandom_range(1, 5000);
      default: clock_speed = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom_range(1000, 200000);
    endcase
    cutoff        = 3'($urandom_range(0, 7));
    square_volume = int'($urandom_range(0, 32'h0040_0000)) - 32'sh0020_0000;
    saw_volume    = int'($urandom_range(0, 32'h0040_0000)) - 32'sh0020_0000;
    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(0, 15));
      if (sel == 0)
        frequency[i] = '0;
      else if (sel == 1)
        frequency[i] = -int'($urandom_range(1, 32'h7FFF_FFFF));
      else
        frequency[i] = int'(($urandom_range(0, 2047) << 20) | $urandom_range(0, 32'h000F_FFFF));
    end
  endtask

  // Monitor: every rising edge presents a sample; compare against the queue.
  initial begin : monitor
    int    e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (synth_out !== 16'(e)) begin
          errors++;
          $display("FAIL %s: synth_out=%0d expected %0d", n, synth_out, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: stimulus did not complete, pending=%0d", exp_q.size());
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : stimulus
    clock_speed   = 32'd48000;
    cutoff        = 3'd0;
    square_volume = 32'sh0008_0000;
    saw_volume    = 32'sh0008_0000;
    set_all_freq('0);
    for (int i = 0; i < 16; i++) m_phase[i] = 0;
    m_y = 0;

    // Asynchronous reset, observed before any clock edge.
    #1 reset = 1'b1;
    #1 check_now("reset_async", 0);
    @(negedge clk);
    cycle("reset_hold", 1'b1, 0);
    cycle("reset_hold", 1'b1, 0);
    reset = 1'b0;
    repeat (4) cycle("release_const", 1'b1, 16383);

    // Quarter-rate tone: 1000 Hz at 4000 Hz steps the phase by 2^30 per sample.
    apply_reset();
    clock_speed = 32'd4000;
    set_all_freq(32'sd1000 <<< 20);
    for (int k = 0; k < 11; k++) cycle("waveform", 1'b1, wave[k % 4]);
    #2 reset = 1'b1;
    #1 check_now("midrun_reset", 0);
    cycle("midrun_hold", 1'b1, 0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) cycle("waveform_restart", 1'b1, wave[k % 4]);

    // Filter step response.
    apply_reset();
    clock_speed = 32'd48000;
    set_all_freq('0);
    cutoff = 3'd1;
    cycle("filter", 1'b1, 8191);
    cycle("filter", 1'b1, 12287);
    cycle("filter", 1'b1, 14335);
    repeat (16) cycle("filter_settle");
    cutoff = 3'd7;
    repeat (4) cycle("filter_cutoff7");

    // Saturation at both rails.
    apply_reset();
    cutoff = 3'd0;
    square_volume = 32'sh0020_0000;
    saw_volume    = '0;
    repeat (3) cycle("saturate_pos", 1'b1, 32767);
    square_volume = -32'sh0020_0000;
    repeat (3) cycle("saturate_neg", 1'b1, -32768);

    // Zero sample rate freezes every phase.
    apply_reset();
    square_volume = 32'sh0008_0000;
    saw_volume    = 32'sh0008_0000;
    clock_speed   = '0;
    for (int i = 0; i < 16; i++) frequency[i] = int'($urandom_range(1, 32'h7FFF_FFFF));
    repeat (5) cycle("guard_zero_rate", 1'b1, 16383);
    clock_speed = 32'd4000;
    set_all_freq(32'sd1000 <<< 20);
    repeat (3) cycle("guard_run");
    clock_speed = '0;
    repeat (4) cycle("guard_frozen");

    // Randomized segments; input changes never reset phase or filter state.
    for (int s = 0; s < 40; s++) begin
      randomize_inputs();
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        cycle("random_reset");
        reset = 1'b0;
      end
      repeat ($urandom_range(1, 8)) cycle("random");
    end

    stim_done = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
